// File: rtl/ps2_host_cmd_ctrl.sv
// Host-to-keyboard PS/2 command sequencer: round-robin LED/command arbitration, inhibit/RTS,
// device-clocked shift-out with ACK check, response frame check, FE resend and watchdog abort.
module ps2_host_cmd_ctrl #(
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int RETRIES     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       led_req,
   input  logic [2:0] led_val,
   input  logic       cmd_req,
   input  logic [7:0] cmd_byte,
   output logic       led_ack,
   output logic       cmd_ack,
   output logic       err,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       busy,
   output logic       rx_hold
);

   localparam int CW = ($clog2(INHIBIT_CYC + 1) > 4) ? $clog2(INHIBIT_CYC + 1) : 4;
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACKBIT, S_RESP} state_t;

   state_t        r_state, w_nxt;
   logic          r_clk_s1, r_clk_s2, r_clk_s3, r_dat_s1, r_dat_s2;
   logic [CW-1:0] r_cnt;
   logic [WW-1:0] r_wd;
   logic [RW-1:0] r_retry;
   logic [7:0]    r_byte;
   logic [8:0]    r_sh;
   logic [9:0]    r_rx;
   logic [2:0]    r_led_val;
   logic          r_is_led, r_last_led, r_step;
   logic          r_clk_oe, r_data_oe, r_led_ack, r_cmd_ack, r_err, r_rx_valid;
   logic [7:0]    r_rx_byte;
   logic          w_fe, w_wd_exp, w_frame_ok;
   logic [10:0]   w_frame;
   logic          w_grant_led, w_grant_cmd, w_fail, w_ok, w_resend, w_next_byte, w_rx_good;

   assign w_fe       = r_clk_s3 & ~r_clk_s2;
   assign w_wd_exp   = (r_wd == WW'(TIMEOUT_CYC - 1));
   assign w_frame    = {r_dat_s2, r_rx};
   assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

   always_comb begin
      w_nxt       = r_state;
      w_grant_led = 1'b0;
      w_grant_cmd = 1'b0;
      w_fail      = 1'b0;
      w_ok        = 1'b0;
      w_resend    = 1'b0;
      w_next_byte = 1'b0;
      w_rx_good   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Arbitration waits out the ack cycle so a requester can drop its level first.
            if (!r_led_ack && !r_cmd_ack) begin
               if (led_req && (!cmd_req || !r_last_led)) w_grant_led = 1'b1;
               else if (cmd_req)                         w_grant_cmd = 1'b1;
            end
         end
         S_INHIBIT: if (r_cnt == CW'(INHIBIT_CYC - 1)) w_nxt = S_REQ;
         S_REQ: begin
            if (w_fe)          w_nxt  = S_SHIFT;
            else if (w_wd_exp) w_fail = 1'b1;
         end
         S_SHIFT: begin
            if (w_fe) begin
               if (r_cnt == CW'(8)) w_nxt = S_ACKBIT;
            end else if (w_wd_exp) w_fail = 1'b1;
         end
         S_ACKBIT: begin
            if (w_fe) begin
               if (r_dat_s2) w_fail = 1'b1;
               else          w_nxt  = S_RESP;
            end else if (w_wd_exp) w_fail = 1'b1;
         end
         S_RESP: begin
            if (w_fe) begin
               if (r_cnt == CW'(10)) begin
                  if (!w_frame_ok) w_fail = 1'b1;
                  else begin
                     w_rx_good = 1'b1;
                     if (w_frame[8:1] == 8'hFE) begin
                        if (r_retry < RW'(RETRIES)) w_resend = 1'b1;
                        else                        w_fail   = 1'b1;
                     end
                     else if (!r_is_led)             w_ok        = 1'b1;
                     else if (w_frame[8:1] != 8'hFA) w_fail      = 1'b1;
                     else if (r_step)                w_ok        = 1'b1;
                     else                            w_next_byte = 1'b1;
                  end
               end
            end else if (w_wd_exp) w_fail = 1'b1;
         end
         default: w_nxt = S_IDLE;
      endcase
      if (w_grant_led || w_grant_cmd || w_resend || w_next_byte) w_nxt = S_INHIBIT;
      if (w_fail || w_ok) w_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_clk_s1   <= 1'b0;
         r_clk_s2   <= 1'b0;
         r_clk_s3   <= 1'b0;
         r_dat_s1   <= 1'b0;
         r_dat_s2   <= 1'b0;
         r_cnt      <= '0;
         r_wd       <= '0;
         r_retry    <= '0;
         r_byte     <= '0;
         r_sh       <= '0;
         r_rx       <= '0;
         r_led_val  <= '0;
         r_is_led   <= 1'b0;
         r_last_led <= 1'b0;
         r_step     <= 1'b0;
         r_clk_oe   <= 1'b0;
         r_data_oe  <= 1'b0;
         r_led_ack  <= 1'b0;
         r_cmd_ack  <= 1'b0;
         r_err      <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_byte  <= '0;
      end else begin
         r_state    <= w_nxt;
         r_clk_s1   <= ps2_clk_in;
         r_clk_s2   <= r_clk_s1;
         r_clk_s3   <= r_clk_s2;
         r_dat_s1   <= ps2_data_in;
         r_dat_s2   <= r_dat_s1;
         r_led_ack  <= 1'b0;
         r_cmd_ack  <= 1'b0;
         r_err      <= 1'b0;
         r_rx_valid <= 1'b0;

         if (w_nxt != r_state) r_cnt <= '0;
         else if (r_state == S_INHIBIT || ((r_state == S_SHIFT || r_state == S_RESP) && w_fe))
            r_cnt <= r_cnt + CW'(1);

         if (w_nxt != r_state || w_fe) r_wd <= '0;
         else if (r_state != S_IDLE && r_state != S_INHIBIT) r_wd <= r_wd + WW'(1);

         if (w_grant_led || w_grant_cmd) begin
            r_is_led   <= w_grant_led;
            r_last_led <= w_grant_led;
            r_byte     <= w_grant_led ? 8'hED : cmd_byte;
            r_led_val  <= led_val;
            r_step     <= 1'b0;
            r_retry    <= '0;
         end
         if (w_next_byte) begin
            r_byte  <= {5'b0, r_led_val};
            r_step  <= 1'b1;
            r_retry <= '0;
         end
         if (w_resend) r_retry <= r_retry + RW'(1);

         if (w_nxt == S_INHIBIT && r_state != S_INHIBIT) begin
            r_clk_oe  <= 1'b1;
            r_data_oe <= 1'b0;
         end
         if (r_state == S_INHIBIT && w_nxt == S_REQ) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
         end
         // Shifter holds {stop, parity, data[7:1]}; bit 0 goes out straight from r_byte.
         if (r_state == S_REQ && w_fe) begin
            r_data_oe <= ~r_byte[0];
            r_sh      <= {1'b1, ~^r_byte, r_byte[7:1]};
         end
         if (r_state == S_SHIFT && w_fe) begin
            r_data_oe <= ~r_sh[0];
            r_sh      <= {1'b1, r_sh[8:1]};
         end
         if (r_state == S_RESP && w_fe) r_rx <= w_frame[10:1];
         if (w_rx_good) begin
            r_rx_byte  <= w_frame[8:1];
            r_rx_valid <= 1'b1;
         end
         if (w_fail || w_ok) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_led_ack <= r_is_led;
            r_cmd_ack <= ~r_is_led;
            r_err     <= w_fail;
         end
      end
   end

   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign led_ack     = r_led_ack;
   assign cmd_ack     = r_cmd_ack;
   assign err         = r_err;
   assign rx_byte     = r_rx_byte;
   assign rx_valid    = r_rx_valid;
   assign busy        = (r_state != S_IDLE);
   assign rx_hold     = busy;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed bench for ps2_host_cmd_ctrl: open-collector bus with a keyboard model that clocks
// host frames in, returns ACK bits and response frames; requesters drop their level on ack.
module tb_ps2_host_cmd_ctrl;
   localparam int INH = 20;
   localparam int TMO = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1, dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic       led_req, cmd_req, led_ack, cmd_ack, err, rx_valid, busy, rx_hold;
   logic       led_req_set = 1'b0, cmd_req_set = 1'b0;
   logic [2:0] led_val = 3'b000;
   logic [7:0] cmd_byte = 8'h00;
   logic [7:0] rx_byte;

   int checks = 0, errors = 0;
   int led_ack_n = 0, cmd_ack_n = 0, ack_n = 0, rxv_n = 0;
   int led_base = 0, cmd_base = 0, acks_exp = 0, nreq = 0, ack_before = 0;
   int inh_n = 0, inh_run = 0, inh_last = 0, cyc = 0, req_cyc = 0, ack_cyc = 0;
   logic       req_dat = 1'b0;
   logic [2:0] last_ack = 3'b000;
   logic [9:0] bits;
   logic [7:0] rsp;

   always #5 clk = ~clk;

   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;
   assign led_req     = led_req_set && (led_ack_n == led_base);
   assign cmd_req     = cmd_req_set && (cmd_ack_n == cmd_base);

   ps2_host_cmd_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .RETRIES(2)) dut (
      .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .led_req(led_req), .led_val(led_val), .cmd_req(cmd_req), .cmd_byte(cmd_byte),
      .led_ack(led_ack), .cmd_ack(cmd_ack), .err(err), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .busy(busy), .rx_hold(rx_hold)
   );

   // Observer: ack/rx_valid counts, inhibit length and request-to-send timestamps.
   always @(negedge clk) begin
      cyc++;
      if (led_ack) led_ack_n++;
      if (cmd_ack) cmd_ack_n++;
      if (led_ack || cmd_ack) begin
         last_ack = {led_ack, cmd_ack, err};
         ack_cyc  = cyc;
         ack_n++;
      end
      if (rx_valid) rxv_n++;
      if (ps2_clk_oe) inh_run++;
      else if (inh_run != 0) begin
         inh_last = inh_run;
         req_dat  = ps2_data_oe;
         req_cyc  = cyc;
         inh_run  = 0;
         inh_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      nreq++;
      for (int i = 0; i < 3000 && inh_n < nreq; i++) @(negedge clk);
      chk("req_wait", inh_n, nreq);
   endtask

   task automatic wait_ack();
      acks_exp++;
      for (int i = 0; i < 600 && ack_n < acks_exp; i++) @(negedge clk);
      chk("ack_wait", ack_n, acks_exp);
   endtask

   task automatic dev_bit_clk();
      repeat (4) @(negedge clk);
      dev_clk = 1'b0;
      repeat (8) @(negedge clk);
      dev_clk = 1'b1;
   endtask

   task automatic dev_rx(input logic ack_bit, output logic [9:0] b);
      for (int i = 0; i < 10; i++) begin
         dev_bit_clk();
         b[i] = ps2_data_in;
      end
      dev_data = ack_bit;
      dev_bit_clk();
      repeat (4) @(negedge clk);
      dev_data = 1'b1;
   endtask

   task automatic dev_tx(input logic [7:0] b, input logic par_flip, input logic stop_bit);
      logic [10:0] f;
      f = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         dev_data = f[i];
         dev_bit_clk();
      end
      repeat (4) @(negedge clk);
      dev_data = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_outputs", 32'({ps2_clk_oe, ps2_data_oe, led_ack, cmd_ack, err, rx_valid, busy, rx_hold}), 0);
      chk("rst_rx_byte", 32'(rx_byte), 0);
      led_val = 3'b100; cmd_byte = 8'hEE; led_req_set = 1'b1; cmd_req_set = 1'b1;
      @(negedge clk);
      chk("rst_holds_idle", 32'(busy), 0);
      rst = 1'b0;

      // Both requesting out of reset: LED first, then the command.
      wait_req();
      chk("led_inhibit_len", inh_last, INH);
      chk("req_start_bit", 32'(req_dat), 1);
      chk("busy_rx_hold", 32'({busy, rx_hold}), 3);
      led_val = 3'b011;
      dev_rx(1'b0, bits);
      chk("led_first_byte", 32'(bits[7:0]), 32'hED);
      chk("led_ed_parity", 32'(bits[8]), 1);
      chk("led_stop_release", 32'(bits[9]), 1);
      dev_tx(8'hFA, 1'b0, 1'b1);
      wait_req();
      chk("led2_inhibit_len", inh_last, INH);
      dev_rx(1'b0, bits);
      chk("led_val_byte", 32'(bits[7:0]), 32'h04);
      chk("led_04_parity", 32'(bits[8]), 0);
      dev_tx(8'hFA, 1'b0, 1'b1);
      wait_ack();
      chk("led_ack_ok", 32'(last_ack), 32'b100);
      chk("led_rx_count", rxv_n, 2);
      chk("led_rx_byte", 32'(rx_byte), 32'hFA);
      wait_req();
      cmd_byte = 8'h00;
      dev_rx(1'b0, bits);
      chk("cmd_second_byte", 32'(bits[7:0]), 32'hEE);
      dev_tx(8'hEE, 1'b0, 1'b1);
      wait_ack();
      chk("cmd_ack_ok", 32'(last_ack), 32'b010);
      chk("cmd_rx_byte", 32'(rx_byte), 32'hEE);
      chk("cmd_rx_count", rxv_n, 3);

      // LED alone, keyboard returns ACK bit = 1.
      led_val = 3'b001; led_base = led_ack_n;
      wait_req();
      dev_rx(1'b1, bits);
      wait_ack();
      chk("ackbit_err", 32'(last_ack), 32'b101);
      chk("ackbit_idle", 32'({busy, ps2_clk_oe, ps2_data_oe}), 0);

      // Both again with last grant = LED: command first, answered FE, FE, FA.
      cmd_byte = 8'hF4; led_val = 3'b010;
      led_base = led_ack_n; cmd_base = cmd_ack_n;
      for (int k = 0; k < 3; k++) begin
         wait_req();
         dev_rx(1'b0, bits);
         chk("resend_byte", 32'(bits[7:0]), 32'hF4);
         rsp = (k == 2) ? 8'hFA : 8'hFE;
         dev_tx(rsp, 1'b0, 1'b1);
      end
      wait_ack();
      chk("resend_ack_ok", 32'(last_ack), 32'b010);
      chk("resend_rx_count", rxv_n, 6);
      wait_req();
      dev_rx(1'b0, bits);
      chk("rr_led_after_cmd", 32'(bits[7:0]), 32'hED);
      dev_tx(8'hFA, 1'b1, 1'b1);
      wait_ack();
      chk("bad_parity_err", 32'(last_ack), 32'b101);
      chk("bad_parity_no_rxv", rxv_n, 6);
      chk("bad_parity_rx_byte", 32'(rx_byte), 32'hFA);

      // Retries exhausted: three FE answers.
      cmd_base = cmd_ack_n;
      for (int k = 0; k < 3; k++) begin
         wait_req();
         dev_rx(1'b0, bits);
         chk("fe3_byte", 32'(bits[7:0]), 32'hF4);
         dev_tx(8'hFE, 1'b0, 1'b1);
      end
      wait_ack();
      chk("fe3_err", 32'(last_ack), 32'b011);
      chk("fe3_rx_byte", 32'(rx_byte), 32'hFE);
      repeat (40) @(negedge clk);
      chk("fe3_no_4th_send", inh_n, nreq);

      // Response frame with stop = 0.
      cmd_byte = 8'hEE; cmd_base = cmd_ack_n;
      wait_req();
      dev_rx(1'b0, bits);
      dev_tx(8'hFA, 1'b0, 1'b0);
      wait_ack();
      chk("bad_stop_err", 32'(last_ack), 32'b011);
      chk("bad_stop_no_rxv", rxv_n, 9);

      // Keyboard never clocks after the request-to-send.
      cmd_base = cmd_ack_n;
      wait_req();
      wait_ack();
      chk("timeout_cycles", ack_cyc - req_cyc, TMO);
      chk("timeout_err", 32'(last_ack), 32'b011);
      @(negedge clk);
      chk("timeout_released", 32'({ps2_clk_oe, ps2_data_oe, busy}), 0);

      // Reset at the fifth device clock fall; LED request stays held.
      led_val = 3'b110; led_base = led_ack_n;
      wait_req();
      for (int i = 0; i < 4; i++) dev_bit_clk();
      repeat (4) @(negedge clk);
      dev_clk = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_data_low", 32'(ps2_data_oe), 1);
      #2 rst = 1'b1;
      #1 chk("rst_async_release", 32'({ps2_clk_oe, ps2_data_oe, busy}), 0);
      ack_before = ack_n;
      repeat (3) @(negedge clk);
      dev_clk = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_ack", ack_n, ack_before);
      wait_req();
      chk("restart_inhibit_len", inh_last, INH);
      dev_rx(1'b0, bits);
      chk("restart_byte", 32'(bits[7:0]), 32'hED);
      dev_tx(8'hFA, 1'b0, 1'b1);
      wait_req();
      dev_rx(1'b0, bits);
      chk("restart_led_byte", 32'(bits[9:0]), 32'h306);
      dev_tx(8'hFA, 1'b0, 1'b1);
      wait_ack();
      chk("restart_ack_ok", 32'(last_ack), 32'b100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2_host_cmd_ctrl.md
Name: ps2_host_cmd_ctrl

Overview:
- Host-to-keyboard PS/2 command sequencer; sits beside the receive-only PS/2 keyboard driver on the same two-wire bus.
- Arbitrates two requesters: the LED updater (caps/rus/scroll) and a generic single-byte command port.
- Serializes each byte with bus inhibit, device-clocked shift-out and ACK-bit check, then receives and checks the keyboard's response frame.
- Handles FE resend and timeout; raises rx_hold so the keyboard decoder ignores command-response traffic.

Parameters:
- INHIBIT_CYC, 5000: clk cycles ps2_clk is held low before the request-to-send (100 us at 50 MHz).
- TIMEOUT_CYC, 1000000: max clk cycles between device clock falling edges, or while waiting for the first edge, before abort.
- RETRIES, 2: resend attempts after an FE response before an error is reported.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ps2_clk_in  in  1  raw PS/2 clock pin
- ps2_data_in  in  1  raw PS/2 data pin
- ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
- ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release
- led_req  in  1  LED update request, level, held until led_ack
- led_val  in  3  LED bits {caps, num, scroll}, sampled at grant
- cmd_req  in  1  command request, level, held until cmd_ack
- cmd_byte  in  8  command byte, sampled at grant
- led_ack  out  1  one-cycle pulse, LED transaction finished
- cmd_ack  out  1  one-cycle pulse, command transaction finished
- err  out  1  one-cycle pulse coincident with ack when the transaction failed
- rx_byte  out  8  last response byte received
- rx_valid  out  1  one-cycle pulse, rx_byte updated
- busy  out  1  1 whenever state != IDLE
- rx_hold  out  1  equals busy; keyboard decoder discards events while set

Behaviour:
- Reset values: every output 0, state IDLE, all counters 0, last_grant = CMD. Assertion of rst releases both lines immediately, including mid-frame.
- Input sync: 2-flop synchronizers on both pins. A falling edge (fe) is a 1->0 transition of the synchronized clock and is a one-cycle internal strobe.
- Arbitration in IDLE uses round-robin. If only one request is asserted, it is granted. If both are asserted, the requester not equal to last_grant is granted. last_grant updates at grant. Grant occurs the cycle after the request is seen.
- LED transaction: send 0xED, expect 0xFA, then send {5'b0, led_val}, expect 0xFA, then led_ack.
- CMD transaction: send cmd_byte. Any checked response other than 0xFE completes with cmd_ack and err = 0.
- INHIBIT state: ps2_clk_oe = 1 for exactly INHIBIT_CYC cycles.
- REQ state: entered with ps2_clk_oe = 0 and ps2_data_oe = 1 in the same cycle; this drives the start bit. Wait for fe.
- SHIFT state: on each fe, present the next bit using ps2_data_oe = ~bit.
  - fe 1 through fe 8 present data bits 0..7, LSB first.
  - fe 9 presents parity = ~^byte (odd parity).
  - fe 10 releases the line (stop bit = 1).
- ACKBIT state: on fe 11, sample data. Data 0 goes to RESP; data 1 is an error.
- RESP state: sample data on 11 falling edges. Check start = 0, parity odd over data+parity, stop = 1. Any check failure is an error. On a good frame: rx_byte updates and rx_valid pulses one cycle after the 11th fe.
- Response decision:
  - 0xFE with retry_cnt < RETRIES: increment retry_cnt and resend the same byte from INHIBIT.
  - 0xFE with retries exhausted: error.
  - LED step with a response other than 0xFA or 0xFE: error.
  - retry_cnt resets per byte.
- Timeout: a watchdog counter clears on every fe and on state entry. It runs in REQ, SHIFT, ACKBIT and RESP. Reaching TIMEOUT_CYC is an error.
- Error handling: release both lines, pulse the granted requester's ack together with err, return to IDLE. A partial LED sequence is not resumed.
- Completion: ack pulses exactly one cycle and the block returns to IDLE in that cycle. A request still held after ack is re-arbitrated from the next cycle.
- Request changes: requests dropping mid-transaction are ignored; the transaction completes. led_val and cmd_byte changes after grant have no effect.

Test Plan:
- LED path: led_req = 1, led_val = 3'b100, device model ACKs and answers FA both times -> frames ED (parity 1) then 04 (parity 0) observed on the bus; ps2_clk_oe low for exactly 5000 cycles before each frame; rx_valid pulses twice with FA; one led_ack, err = 0.
- Resend: cmd_byte = 0xF4, device answers FE, FE, FA -> 0xF4 sent 3 times, cmd_ack with err = 0. Device answers FE three times -> 3 sends, cmd_ack with err = 1.
- Timeout: device never clocks after the inhibit -> ack plus err pulse exactly TIMEOUT_CYC cycles after REQ entry; both oe = 0 afterwards; busy = 0.
- Arbitration: led_req and cmd_req both asserted from reset -> LED served first (last_grant reset = CMD), then command; both held again -> order alternates.
- Response frame error: FA response sent with bad parity, or with stop = 0 -> no rx_valid, ack with err = 1. ACK bit returned as 1 -> err = 1.
- Reset mid-frame: rst asserted at fe 5 of SHIFT -> ps2_clk_oe = ps2_data_oe = 0 in the same cycle (async); busy = 0; no ack. After rst release with led_req held, the full LED sequence restarts from INHIBIT.
